// File: rtl/multi_cycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multi_cycle_control_fsm
//   Main control FSM of the multi-cycle RV32I core. It steps each
//   instruction through IF -> ID -> EX -> (BR_TAKEN | MEM) -> WB and drives
//   every datapath enable and mux select. alu_op encoding toward the ALU
//   control decoder: 00 = add, 01 = branch compare, 10 = funct3/funct7 op.
//
// Ports
//   clk        core clock, rising edge
//   reset_n    asynchronous active-low reset (state -> IF at once)
//   opcode     IR[6:0], stable from ID onward
//   bcond      branch-taken flag from the ALU (EX, branches)
//   mem_ready  memory completes the current access this cycle
//   halt_req   x17 == 10, valid in ID
//   pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0]
//              datapath controls
//   is_halted  high while in HALT
// ---------------------------------------------------------------------------
module multi_cycle_control_fsm #(
  parameter bit HALT_ON_ECALL = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       is_halted
);

  typedef enum logic [2:0] {
    S_IF       = 3'd0,
    S_ID       = 3'd1,
    S_EX       = 3'd2,
    S_BR_TAKEN = 3'd3,
    S_MEM      = 3'd4,
    S_WB       = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_e state_q, state_d;
  logic   known_op;
  logic   id_halt;

  // Opcodes that have an EX-phase; anything else retires from ID as a no-op.
  always_comb begin
    known_op = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  assign id_halt = (opcode == OP_SYSTEM) && halt_req && HALT_ON_ECALL;

  // State register: reset is asynchronous so an in-flight MEM/WB write is
  // cancelled in the very cycle reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (id_halt)       state_d = S_HALT;
        else if (known_op) state_d = S_EX;
        else               state_d = S_IF;
      end
      S_EX: begin
        case (opcode)
          OP_R, OP_I:          state_d = S_WB;
          OP_LOAD, OP_STORE:   state_d = S_MEM;
          OP_BRANCH:           state_d = bcond ? S_BR_TAKEN : S_IF;
          default:             state_d = S_IF;
        endcase
      end
      S_BR_TAKEN: state_d = S_IF;
      S_MEM: begin
        if (mem_ready) state_d = (opcode == OP_LOAD) ? S_WB : S_IF;
      end
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Output logic
  always_comb begin
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    is_halted  = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
      end
      S_ID: begin
        alu_src_b = 2'b01;
        // ecall that does not halt, or an unknown opcode, retires here.
        pc_write  = !id_halt && ((opcode == OP_SYSTEM) || !known_op);
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
          end
          OP_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
          end
          OP_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            // Not taken: ALUOut still holds PC+4 from ID.
            pc_write  = !bcond;
            pc_source = !bcond;
          end
          OP_JAL, OP_JALR: begin
            // rd gets ALUOut (PC+4) while the ALU forms the jump target.
            alu_src_a = (opcode == OP_JALR);
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            reg_write = 1'b1;
          end
          default: ;
        endcase
      end
      S_BR_TAKEN: begin
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = (opcode == OP_LOAD);
        mem_write = (opcode == OP_STORE);
        if (mem_ready && (opcode == OP_STORE)) begin
          alu_src_b = 2'b01;
          pc_write  = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (opcode == OP_LOAD);
        alu_src_b  = 2'b01;
        pc_write   = 1'b1;
      end
      S_HALT: is_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
module tb_multi_cycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       bcond, mem_ready, halt_req;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, is_halted;
  logic [1:0] alu_src_b, alu_op;

  multi_cycle_control_fsm #(.HALT_ON_ECALL(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .bcond(bcond),
    .mem_ready(mem_ready), .halt_req(halt_req),
    .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] I   = 7'b0010011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] JLR = 7'b1100111;
  localparam logic [6:0] SYS = 7'b1110011;
  localparam logic [6:0] LUI = 7'b0110111;

  // {pc_write,pc_source,i_or_d,mem_read,mem_write,ir_write,mem_to_reg,
  //  reg_write,alu_src_a} , alu_src_b , alu_op , is_halted
  localparam logic [13:0] E_IF0     = {9'b000100000, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_IF1     = {9'b000101000, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_ID      = {9'b000000000, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] E_ID_SKIP = {9'b100000000, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] E_EX_R    = {9'b000000001, 2'b00, 2'b10, 1'b0};
  localparam logic [13:0] E_EX_I    = {9'b000000001, 2'b10, 2'b10, 1'b0};
  localparam logic [13:0] E_EX_LS   = {9'b000000001, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_EX_BNT  = {9'b110000001, 2'b00, 2'b01, 1'b0};
  localparam logic [13:0] E_EX_BT   = {9'b000000001, 2'b00, 2'b01, 1'b0};
  localparam logic [13:0] E_EX_JAL  = {9'b100000010, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_EX_JALR = {9'b100000011, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_BR_TKN  = {9'b100000000, 2'b10, 2'b00, 1'b0};
  localparam logic [13:0] E_MEM_LD  = {9'b001100000, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_MEM_STW = {9'b001010000, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] E_MEM_STD = {9'b101010000, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] E_WB_ALU  = {9'b100000010, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] E_WB_LD   = {9'b100000110, 2'b01, 2'b00, 1'b0};
  localparam logic [13:0] E_HALT    = {9'b000000000, 2'b00, 2'b00, 1'b1};

  typedef struct {
    logic [13:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  wire [13:0] act = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, is_halted};

  // Monitor: the FSM presents a control word every cycle; each queued
  // expectation is matched against the mid-cycle sample.
  initial begin
    while (!done) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        if (act !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %b want %b", e.name, act, e.v);
        end
      end
    end
  end

  // Drive one cycle of inputs (just after the rising edge) and queue the
  // control word expected during that cycle.
  task automatic step(input logic [6:0] op, input logic bc, input logic mr,
                      input logic hr, input logic [13:0] ev, input string nm);
    opcode = op; bcond = bc; mem_ready = mr; halt_req = hr;
    sb.push_back('{ev, nm});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got no end want end");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; opcode = 7'd0; bcond = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;
    @(posedge clk); #1;
    step(R, 0, 0, 0, E_IF0, "reset_state");
    step(R, 0, 1, 0, E_IF1, "reset_ir_write");
    reset_n = 1'b1;

    // add: IF ID EX WB
    step(R, 0, 1, 0, E_IF1,    "add_if");
    step(R, 0, 1, 0, E_ID,     "add_id");
    step(R, 0, 1, 0, E_EX_R,   "add_ex");
    step(R, 0, 1, 0, E_WB_ALU, "add_wb");
    // addi
    step(I, 0, 1, 0, E_IF1,    "addi_if");
    step(I, 0, 1, 0, E_ID,     "addi_id");
    step(I, 0, 1, 0, E_EX_I,   "addi_ex");
    step(I, 0, 1, 0, E_WB_ALU, "addi_wb");
    // lw with three wait cycles in MEM: 8 cycles
    step(LD, 0, 1, 0, E_IF1,    "lw_if");
    step(LD, 0, 1, 0, E_ID,     "lw_id");
    step(LD, 0, 1, 0, E_EX_LS,  "lw_ex");
    for (int k = 0; k < 3; k++) step(LD, 0, 0, 0, E_MEM_LD, "lw_mem_wait");
    step(LD, 0, 1, 0, E_MEM_LD, "lw_mem_done");
    step(LD, 0, 1, 0, E_WB_LD,  "lw_wb");
    // sw with a slow fetch
    step(ST, 0, 0, 0, E_IF0,     "sw_if_wait");
    step(ST, 0, 1, 0, E_IF1,     "sw_if");
    step(ST, 0, 1, 0, E_ID,      "sw_id");
    step(ST, 0, 1, 0, E_EX_LS,   "sw_ex");
    step(ST, 0, 1, 0, E_MEM_STD, "sw_mem_done");
    // beq not taken / taken
    step(BR, 0, 1, 0, E_IF1,    "bnt_if");
    step(BR, 0, 1, 0, E_ID,     "bnt_id");
    step(BR, 0, 1, 0, E_EX_BNT, "bnt_ex");
    step(BR, 1, 1, 0, E_IF1,    "bt_if");
    step(BR, 1, 1, 0, E_ID,     "bt_id");
    step(BR, 1, 1, 0, E_EX_BT,  "bt_ex");
    step(BR, 0, 1, 0, E_BR_TKN, "bt_taken");
    // jal / jalr
    step(JAL, 0, 1, 0, E_IF1,     "jal_if");
    step(JAL, 0, 1, 0, E_ID,      "jal_id");
    step(JAL, 0, 1, 0, E_EX_JAL,  "jal_ex");
    step(JLR, 0, 1, 0, E_IF1,     "jalr_if");
    step(JLR, 0, 1, 0, E_ID,      "jalr_id");
    step(JLR, 0, 1, 0, E_EX_JALR, "jalr_ex");
    // unknown opcode and non-halting ecall retire from ID
    step(LUI, 0, 1, 0, E_IF1,     "lui_if");
    step(LUI, 0, 1, 0, E_ID_SKIP, "lui_id");
    step(SYS, 0, 1, 0, E_IF1,     "ecall0_if");
    step(SYS, 0, 1, 0, E_ID_SKIP, "ecall0_id");
    step(R,   0, 1, 0, E_IF1,     "after_ecall0_if");
    step(R,   0, 1, 0, E_ID,      "after_ecall0_id");
    step(R,   0, 1, 0, E_EX_R,    "after_ecall0_ex");
    step(R,   0, 1, 0, E_WB_ALU,  "after_ecall0_wb");

    // Async reset in the middle of a stalled store
    step(ST, 0, 1, 0, E_IF1,     "rst_sw_if");
    step(ST, 0, 1, 0, E_ID,      "rst_sw_id");
    step(ST, 0, 1, 0, E_EX_LS,   "rst_sw_ex");
    step(ST, 0, 0, 0, E_MEM_STW, "rst_sw_mem_wait");
    reset_n = 1'b0;
    step(ST, 0, 0, 0, E_IF0,     "rst_mid_mem");
    step(ST, 0, 1, 0, E_IF1,     "rst_held");
    reset_n = 1'b1;
    step(R, 0, 1, 0, E_IF1,    "post_rst_if");
    step(R, 0, 1, 0, E_ID,     "post_rst_id");
    step(R, 0, 1, 0, E_EX_R,   "post_rst_ex");
    step(R, 0, 1, 0, E_WB_ALU, "post_rst_wb");

    // Halting ecall
    step(SYS, 0, 1, 1, E_IF1,  "ecall_if");
    step(SYS, 0, 1, 1, E_ID,   "ecall_id");
    step(SYS, 0, 1, 1, E_HALT, "halt_0");
    step(R,   1, 1, 0, E_HALT, "halt_1");
    step(ST,  0, 1, 0, E_HALT, "halt_2");
    step(LD,  0, 0, 1, E_HALT, "halt_3");
    reset_n = 1'b0;
    step(R, 0, 0, 0, E_IF0, "rst_from_halt");
    reset_n = 1'b1;
    step(R, 0, 1, 0, E_IF1, "post_halt_if");
    step(R, 0, 1, 0, E_ID,  "post_halt_id");

    @(negedge clk);
    @(negedge clk);
    #1;
    done = 1'b1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
